// File: rtl/bidir_bus_port.sv
// Registered bidirectional bus port: a small FSM times write drive, post-write
// turnaround and pre-read settle, so core logic never touches the output enable.
module bidir_bus_port #(
  parameter int WIDTH         = 8,
  parameter int HOLD_CYCLES   = 2,
  parameter int TURN_CYCLES   = 1,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             WrReq,
  input  logic [WIDTH-1:0] WrData,
  output logic             WrAck,
  input  logic             RdReq,
  output logic [WIDTH-1:0] RdData,
  output logic             RdValid,
  output logic             Busy,
  output logic             OE,
  output logic [WIDTH-1:0] BusIn,
  inout  wire  [WIDTH-1:0] IOpin,
  output logic [1:0]       DbgState
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DRIVE  = 2'd1;
  localparam logic [1:0] TURN   = 2'd2;
  localparam logic [1:0] SETTLE = 2'd3;

  localparam int MAXC_HT = (HOLD_CYCLES > TURN_CYCLES) ? HOLD_CYCLES : TURN_CYCLES;
  localparam int MAXC    = (MAXC_HT > SETTLE_CYCLES) ? MAXC_HT : SETTLE_CYCLES;
  localparam int CW      = (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam logic [CW-1:0] HOLD_LD   = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] TURN_LD   = CW'(TURN_CYCLES - 1);
  localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE_CYCLES - 1);

  logic [1:0]       state, state_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [WIDTH-1:0] wdata;
  logic             load_wr;
  logic             capture;

  // Counter holds the remaining cycles after the current one; 0 means last cycle.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    load_wr = 1'b0;
    capture = 1'b0;
    case (state)
      IDLE: begin
        if (WrReq) begin
          state_n = DRIVE;
          cnt_n   = HOLD_LD;
          load_wr = 1'b1;
        end else if (RdReq) begin
          state_n = SETTLE;
          cnt_n   = SETTLE_LD;
        end
      end
      DRIVE: begin
        if (cnt == '0) begin
          state_n = TURN;
          cnt_n   = TURN_LD;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      TURN: begin
        if (cnt == '0) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      SETTLE: begin
        if (cnt == '0) begin
          state_n = IDLE;
          cnt_n   = '0;
          capture = 1'b1;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // OE and WrAck are decoded from the next state so the pin enable is a clean flop.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state   <= IDLE;
      cnt     <= '0;
      wdata   <= '0;
      OE      <= 1'b0;
      WrAck   <= 1'b0;
      RdValid <= 1'b0;
      RdData  <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      OE      <= (state_n == DRIVE);
      WrAck   <= (state_n == DRIVE) && (cnt_n == '0);
      RdValid <= capture;
      if (load_wr) wdata  <= WrData;
      if (capture) RdData <= IOpin;
    end
  end

  assign IOpin    = OE ? wdata : {WIDTH{1'bz}};
  assign BusIn    = IOpin;
  assign Busy     = (state != IDLE);
  assign DbgState = state;

endmodule
